trans_cntr_mem: RTL

Bank of NUM_CNTR synchronous transition (power) counters. Each counter accumulates the number of bit toggles per cycle on its own MON_W-bit monitored channel. A register-style host port reads, presets and clears the counters. This block is the clocked, parametrised generation of the transition-counter memory, used by the power-estimation testbenches to profile switching activity on internal buses.

---
 rtl/trans_cntr_mem.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/trans_cntr_mem.sv
// Bank of transition (toggle) counters with a register-style host port.
// Each counter accumulates popcount(mon_i ^ prev_i) per cycle on its own channel.
module trans_cntr_mem #(
  parameter int unsigned NUM_CNTR = 5,
  parameter int unsigned DIR_W    = 3,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MON_W    = 8,
  parameter int unsigned SAT      = 0
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic [NUM_CNTR*MON_W-1:0] mon,
  input  logic [NUM_CNTR-1:0]       cnt_en,
  input  logic                      clr_all,
  input  logic                      req,
  input  logic                      we,
  input  logic [DIR_W-1:0]          dir,
  input  logic [CNT_W-1:0]          wdata,
  output logic [CNT_W-1:0]          rdata,
  output logic                      rvalid,
  output logic                      err,
  output logic [NUM_CNTR-1:0]       ovf
);

  // Popcount widened to CNT_W+1 so it adds straight into the overflow-detecting sum.
  function automatic logic [CNT_W:0] popcnt(input logic [MON_W-1:0] x);
    logic [CNT_W:0] c;
    c = '0;
    for (int b = 0; b < MON_W; b++) begin
      c = c + (CNT_W+1)'(x[b]);
    end
    return c;
  endfunction

  logic [NUM_CNTR*MON_W-1:0] prev_q;
  logic                      prime_q;
  logic [NUM_CNTR*CNT_W-1:0] cnt_flat;
  logic [NUM_CNTR-1:0]       wr_sel;
  logic                      in_range;
  logic [CNT_W-1:0]          rd_val;
  logic [CNT_W-1:0]          rdata_q;
  logic                      rvalid_q;
  logic                      err_q;

  // Extra bit keeps the compare meaningful when NUM_CNTR == 2**DIR_W.
  assign in_range = ({1'b0, dir} < (DIR_W+1)'(NUM_CNTR));

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CNTR; i++) begin
      wr_sel[i] = req && we && in_range && (dir == DIR_W'(i));
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CNTR; i++) begin
      if (dir == DIR_W'(i)) begin
        rd_val = cnt_flat[i*CNT_W +: CNT_W];
      end
    end
  end

  for (genvar g = 0; g < NUM_CNTR; g++) begin : g_ch
    logic [MON_W-1:0] diff;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    assign diff = mon[g*MON_W +: MON_W] ^ prev_q[g*MON_W +: MON_W];
    assign sum  = {1'b0, cnt_q} + popcnt(diff);

    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr_all) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (wr_sel[g]) begin
        cnt_d = wdata;
        ovf_d = 1'b0;
      end else if (prime_q && cnt_en[g]) begin
        if (sum[CNT_W]) begin
          ovf_d = 1'b1;
          cnt_d = (SAT != 0) ? '1 : sum[CNT_W-1:0];
        end else begin
          cnt_d = sum[CNT_W-1:0];
        end
      end
    end

    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign cnt_flat[g*CNT_W +: CNT_W] = cnt_q;
    assign ovf[g]                     = ovf_q;
  end

  // prev samples every edge; prime blocks counting on the first edge after reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      prev_q  <= '0;
      prime_q <= 1'b0;
    end else begin
      prev_q  <= mon;
      prime_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      if (req) begin
        if (!in_range) begin
          err_q <= 1'b1;
          if (!we) begin
            rdata_q <= '0;
          end
        end else if (!we) begin
          rvalid_q <= 1'b1;
          rdata_q  <= rd_val;
        end
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;

endmodule
